// File: rtl/ramb4_s1_byte_reader.sv
// Bit-serial reader for a 4096x1 block RAM port, packing bits LSB-first into bytes.
// Optional even-parity output DOUT_PAR when RAMB4_S1_BYTE_READER_PARITY_EN is defined.
module ramb4_s1_byte_reader #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 10
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] START_ADDR,
   input  logic [CNT_W-1:0]  BYTE_COUNT,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic              RAM_RST,
   output logic              RAM_DI,
   input  logic              RAM_DO,
   output logic [7:0]        DOUT,
`ifdef RAMB4_S1_BYTE_READER_PARITY_EN
   output logic              DOUT_PAR,
`endif
   output logic              DOUT_VALID,
   input  logic              DOUT_READY
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_OUT,
      S_FIN
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   addr;
   logic [CNT_W-1:0]    cnt;
   logic [3:0]          bitk;
   logic [6:0]          sreg;
   logic [7:0]          dout_r;
   logic                last_k;
   logic                hs;

   assign last_k = (bitk == 4'd8);
   assign hs     = DOUT_READY;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (START) begin
               state_nx = (BYTE_COUNT == '0) ? S_FIN : S_READ;
            end
         end
         S_READ: begin
            if (last_k) begin
               state_nx = S_OUT;
            end
         end
         S_OUT: begin
            if (hs) begin
               state_nx = (cnt == CNT_W'(1)) ? S_FIN : S_READ;
            end
         end
         S_FIN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      BUSY       = 1'b0;
      DONE       = 1'b0;
      DOUT_VALID = 1'b0;
      RAM_EN     = 1'b0;
      unique case (state)
         S_IDLE: begin
         end
         S_READ: begin
            BUSY   = 1'b1;
            RAM_EN = !bitk[3];
         end
         S_OUT: begin
            BUSY       = 1'b1;
            DOUT_VALID = 1'b1;
         end
         S_FIN: begin
            DONE = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign RAM_ADDR = addr;
   assign RAM_WE   = 1'b0;
   assign RAM_RST  = 1'b0;
   assign RAM_DI   = 1'b0;
   assign DOUT     = dout_r;

   // RAM_DO lags the address by one cycle, so bit k-1 arrives in step k
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         addr   <= '0;
         cnt    <= '0;
         bitk   <= '0;
         sreg   <= '0;
         dout_r <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (START) begin
                  addr <= START_ADDR;
                  cnt  <= BYTE_COUNT;
                  bitk <= '0;
               end
            end
            S_READ: begin
               if (!bitk[3]) begin
                  addr <= addr + ADDR_W'(1);
               end
               if (bitk != 4'd0 && !last_k) begin
                  sreg <= {RAM_DO, sreg[6:1]};
               end
               if (last_k) begin
                  dout_r <= {RAM_DO, sreg};
                  bitk   <= '0;
               end else begin
                  bitk <= bitk + 4'd1;
               end
            end
            S_OUT: begin
               if (hs) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_FIN: begin
            end
            default: begin
            end
         endcase
      end
   end

`ifdef RAMB4_S1_BYTE_READER_PARITY_EN
   logic par_r;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         par_r <= 1'b0;
      end else if (state == S_READ && last_k) begin
         par_r <= ^{RAM_DO, sreg};
      end
   end

   assign DOUT_PAR = par_r;
`endif

endmodule

// File: tb/tb_ramb4_s1_byte_reader.sv
// Scoreboard bench for ramb4_s1_byte_reader with a behavioural 4096x1 RAM.
// Parity output is checked when RAMB4_S1_BYTE_READER_PARITY_EN is defined.
module tb_ramb4_s1_byte_reader;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic [11:0] START_ADDR = '0;
   logic [9:0]  BYTE_COUNT = '0;
   logic        BUSY;
   logic        DONE;
   logic [11:0] RAM_ADDR;
   logic        RAM_EN;
   logic        RAM_WE;
   logic        RAM_RST;
   logic        RAM_DI;
   logic        RAM_DO = 1'b0;
   logic [7:0]  DOUT;
`ifdef RAMB4_S1_BYTE_READER_PARITY_EN
   logic        DOUT_PAR;
`endif
   logic        DOUT_VALID;
   logic        DOUT_READY = 1'b0;

   ramb4_s1_byte_reader #(
      .ADDR_W(12),
      .CNT_W (10)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .START     (START),
      .START_ADDR(START_ADDR),
      .BYTE_COUNT(BYTE_COUNT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .RAM_ADDR  (RAM_ADDR),
      .RAM_EN    (RAM_EN),
      .RAM_WE    (RAM_WE),
      .RAM_RST   (RAM_RST),
      .RAM_DI    (RAM_DI),
      .RAM_DO    (RAM_DO),
      .DOUT      (DOUT),
`ifdef RAMB4_S1_BYTE_READER_PARITY_EN
      .DOUT_PAR  (DOUT_PAR),
`endif
      .DOUT_VALID(DOUT_VALID),
      .DOUT_READY(DOUT_READY)
   );

   always #5 CLK = ~CLK;

   logic mem [0:4095];

   always @(posedge CLK) begin
      if (RAM_EN) RAM_DO <= mem[RAM_ADDR];
   end

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int en_cnt = 0;
   int valid_cnt = 0;
   int tie_err = 0;
   logic [7:0]  sb [$];
   logic [11:0] alog [$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge CLK) begin : mon
      logic [7:0] e;
      if (RAM_EN) begin
         en_cnt++;
         alog.push_back(RAM_ADDR);
      end
      if (DONE) done_cnt++;
      if (DOUT_VALID) valid_cnt++;
      if (RAM_WE || RAM_RST || RAM_DI) tie_err++;
      if (RST_N && DOUT_VALID && DOUT_READY) begin
         if (sb.size() == 0) begin
            check("unexpected_byte", 32'(DOUT), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("dout", 32'(DOUT), 32'(e));
`ifdef RAMB4_S1_BYTE_READER_PARITY_EN
            check("dout_par", 32'(DOUT_PAR), 32'(^e));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start(input logic [11:0] a, input logic [9:0] c);
      START = 1'b1;
      START_ADDR = a;
      BYTE_COUNT = c;
      tick();
      START = 1'b0;
      START_ADDR = 12'($urandom);
      BYTE_COUNT = 10'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!DOUT_VALID && n < 100) begin
         tick();
         n++;
      end
      if (!DOUT_VALID) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!DONE && n < 200) begin
         tick();
         n++;
      end
      if (!DONE) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic load8(input int base, input logic [7:0] v);
      for (int i = 0; i < 8; i++) mem[(base + i) % 4096] = v[i];
   endtask

   initial begin
      int n;
      int d0;
      int e0;
      int v0;
      int err;
      bit ok;
      logic [15:0] w16;
      logic [3:0]  hi4;
      logic [3:0]  lo4;

      for (int i = 0; i < 4096; i++) mem[i] = 1'b0;

      RST_N = 1'b0;
      repeat (3) tick();
      check("reset_outs",
            32'({BUSY, DONE, RAM_EN, DOUT_VALID, RAM_ADDR, DOUT}), 32'd0);
      RST_N = 1'b1;
      tick();

      // single byte from address 0
      load8(0, 8'hA5);
      DOUT_READY = 1'b1;
      alog.delete();
      d0 = done_cnt;
      sb.push_back(8'hA5);
      start(12'd0, 10'd1);
      check("t1_busy_on", 32'(BUSY), 32'd1);
      wait_valid(n);
      check("t1_latency", 32'(n), 32'd9);
      tick();
      check("t1_done", 32'(DONE), 32'd1);
      check("t1_busy_off", 32'(BUSY), 32'd0);
      tick();
      ok = (alog.size() == 8);
      for (int i = 0; i < 8; i++) if (ok && alog[i] != 12'(i)) ok = 0;
      check("t1_addr_seq", 32'(ok), 32'd1);
      check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

      // wrap across the top of the address space
      hi4 = 4'b1011;
      lo4 = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         mem[4092 + i] = hi4[i];
         mem[i] = lo4[i];
      end
      alog.delete();
      sb.push_back(8'h6B);
      start(12'd4092, 10'd1);
      wait_done(n);
      check("t2_done_lat", 32'(n), 32'd10);
      tick();
      ok = (alog.size() == 8);
      for (int i = 0; i < 8; i++)
         if (ok && alog[i] != 12'((4092 + i) % 4096)) ok = 0;
      check("t2_addr_wrap", 32'(ok), 32'd1);

      // backpressure on the first of two bytes
      w16 = 16'h3C5A;
      for (int i = 0; i < 16; i++) mem[i] = w16[i];
      DOUT_READY = 1'b0;
      d0 = done_cnt;
      sb.push_back(8'h5A);
      sb.push_back(8'h3C);
      start(12'd0, 10'd2);
      wait_valid(n);
      e0 = en_cnt;
      err = 0;
      for (int i = 0; i < 5; i++) begin
         if (DOUT !== 8'h5A || DOUT_VALID !== 1'b1 || RAM_EN !== 1'b0) err++;
         tick();
      end
      check("t3_stall_hold", 32'(err), 32'd0);
      check("t3_stall_en", 32'(en_cnt - e0), 32'd0);
      DOUT_READY = 1'b1;
      tick();
      check("t3_gap", 32'(DOUT_VALID), 32'd0);
      wait_valid(n);
      check("t3_throughput", 32'(n + 1), 32'd10);
      wait_done(n);
      tick();
      check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

      // zero-length transfer
      e0 = en_cnt;
      v0 = valid_cnt;
      start(12'd5, 10'd0);
      check("t4_done", 32'(DONE), 32'd1);
      check("t4_busy", 32'(BUSY), 32'd0);
      tick();
      check("t4_done_off", 32'(DONE), 32'd0);
      repeat (3) tick();
      check("t4_no_en", 32'(en_cnt - e0), 32'd0);
      check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);

      // reset in the middle of a read
      d0 = done_cnt;
      start(12'd0, 10'd1);
      repeat (4) tick();
      RST_N = 1'b0;
      tick();
      check("t5_reset_outs",
            32'({BUSY, DONE, RAM_EN, DOUT_VALID, RAM_ADDR, DOUT}), 32'd0);
      RST_N = 1'b1;
      repeat (2) tick();
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      sb.push_back(8'h3C);
      start(12'd8, 10'd1);
      wait_done(n);
      check("t5_restart_lat", 32'(n), 32'd10);
      tick();

      // odd-parity byte
      load8(16, 8'h07);
      sb.push_back(8'h07);
      start(12'd16, 10'd1);
      wait_done(n);
      tick();

      repeat (3) tick();
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("tie_offs", 32'(tie_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
